// File: rtl/bloonstd1_led_sequencer.sv
// LED sequencer: Avalon-MM write master for the LED PIO. It shows a background level value
// and flashes an event pattern on request, writing to the PIO only when the displayed value changes.
module bloonstd1_led_sequencer #(
  parameter int         WIDTH        = 14,
  parameter int         PHASE_CYCLES = 12500000,
  parameter int         FLASH_COUNT  = 3,
  parameter logic [1:0] PIO_ADDR     = 2'd0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] level_value,
  input  logic             level_valid,
  input  logic             event_req,
  input  logic [WIDTH-1:0] event_pattern,
  output logic             event_busy,
  output logic [WIDTH-1:0] shown_value,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata
);

  localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int FW = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_CYCLES - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [PW-1:0]    phase_cnt_reg;
  logic [FW-1:0]    flash_cnt_reg;
  logic [WIDTH-1:0] level_reg;
  logic [WIDTH-1:0] pat_reg;
  logic [WIDTH-1:0] target_next;

  // level_reg tracks the game logic in every state; it only reaches the LEDs once back in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_reg <= '0;
    end else if (level_valid) begin
      level_reg <= level_value;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      phase_cnt_reg <= '0;
      flash_cnt_reg <= '0;
      pat_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (event_req) begin
            pat_reg       <= event_pattern;
            phase_cnt_reg <= '0;
            flash_cnt_reg <= '0;
            state_reg     <= ON;
          end
        end
        ON: begin
          if (phase_cnt_reg == PHASE_LAST) begin
            phase_cnt_reg <= '0;
            state_reg     <= OFF;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end
        OFF: begin
          if (phase_cnt_reg == PHASE_LAST) begin
            phase_cnt_reg <= '0;
            if (flash_cnt_reg == FLASH_LAST) begin
              state_reg <= IDLE;
            end else begin
              flash_cnt_reg <= flash_cnt_reg + 1'b1;
              state_reg     <= ON;
            end
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    target_next = level_reg;
    case (state_reg)
      ON:      target_next = pat_reg;
      OFF:     target_next = '0;
      default: target_next = level_reg;
    endcase
  end

  // shown_value mirrors the PIO register, so a write is issued only on a real change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shown_value    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
    end else if (target_next != shown_value) begin
      shown_value    <= target_next;
      avm_chipselect <= 1'b1;
      avm_write_n    <= 1'b0;
      avm_writedata  <= 32'(target_next);
    end else begin
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
    end
  end

  assign event_busy  = (state_reg != IDLE);
  assign avm_address = PIO_ADDR;

endmodule

// File: tb/tb_bloonstd1_led_sequencer.sv
// Bench for bloonstd1_led_sequencer: per-cycle vector table plus hand-written reset,
// zero-pattern and mid-sequence reset checks, with PHASE_CYCLES=4 and FLASH_COUNT=2.
module tb_bloonstd1_led_sequencer;

  logic        clk;
  logic        reset_n;
  logic [13:0] level_value;
  logic        level_valid;
  logic        event_req;
  logic [13:0] event_pattern;
  logic        event_busy;
  logic [13:0] shown_value;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;

  int n_compared = 0;
  int n_mismatch = 0;

  bloonstd1_led_sequencer #(
    .WIDTH(14), .PHASE_CYCLES(4), .FLASH_COUNT(2), .PIO_ADDR(2'd0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .level_value(level_value), .level_valid(level_valid),
    .event_req(event_req), .event_pattern(event_pattern),
    .event_busy(event_busy), .shown_value(shown_value),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        lv;
    logic [13:0] val;
    logic        ev;
    logic [13:0] pat;
    logic        cs;
    logic [13:0] wd;
    logic [13:0] shown;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic lv, input logic [13:0] val, input logic ev, input logic [13:0] pat,
                     input logic cs, input logic [13:0] wd, input logic [13:0] shown, input logic busy);
    vecs.push_back('{lv, val, ev, pat, cs, wd, shown, busy});
  endtask

  task automatic idle(input int n, input logic [13:0] shown, input logic busy);
    for (int i = 0; i < n; i++) add(1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 14'h0, shown, busy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Starts an event at the next edge, then counts busy cycles and strobes until busy drops.
  task automatic run_event(input logic [13:0] pat, output int busy_n, output int strobe_n);
    @(negedge clk);
    event_req = 1'b1;
    event_pattern = pat;
    @(negedge clk);
    event_req = 1'b0;
    busy_n = 0;
    strobe_n = 0;
    while (event_busy && busy_n < 40) begin
      busy_n++;
      if (avm_chipselect) strobe_n++;
      @(negedge clk);
    end
  endtask

  int busy_n, strobe_n;

  initial begin
    reset_n = 1'b0;
    level_value = '0;
    level_valid = 1'b0;
    event_req = 1'b0;
    event_pattern = '0;

    // Reset state, then 20 idle cycles with no write strobe.
    repeat (2) @(negedge clk);
    check("reset_cs", {31'b0, avm_chipselect}, 32'd0);
    check("reset_write_n", {31'b0, avm_write_n}, 32'd1);
    check("reset_writedata", avm_writedata, 32'd0);
    check("reset_busy", {31'b0, event_busy}, 32'd0);
    check("reset_shown", {18'b0, shown_value}, 32'd0);
    reset_n = 1'b1;
    strobe_n = 0;
    repeat (20) begin
      @(negedge clk);
      if (avm_chipselect) strobe_n++;
    end
    check("idle_strobes", strobe_n, 0);
    check("idle_shown", {18'b0, shown_value}, 32'd0);
    check("idle_busy", {31'b0, event_busy}, 32'd0);

    // All-zero pattern: full-length sequence, no writes.
    run_event(14'h0, busy_n, strobe_n);
    check("zero_pat_busy_cycles", busy_n, 16);
    check("zero_pat_strobes", strobe_n, 0);

    // Reset during the first ON phase, right after the pattern write.
    @(negedge clk);
    event_req = 1'b1;
    event_pattern = 14'h0155;
    @(negedge clk);
    event_req = 1'b0;
    @(negedge clk);
    check("midon_strobe", {31'b0, avm_chipselect}, 32'd1);
    check("midon_shown", {18'b0, shown_value}, 32'h0155);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_busy", {31'b0, event_busy}, 32'd0);
    check("async_rst_shown", {18'b0, shown_value}, 32'd0);
    check("async_rst_cs", {31'b0, avm_chipselect}, 32'd0);
    check("async_rst_write_n", {31'b0, avm_write_n}, 32'd1);
    check("async_rst_writedata", avm_writedata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_event(14'h0155, busy_n, strobe_n);
    check("post_rst_busy_cycles", busy_n, 16);
    check("post_rst_strobes", strobe_n, 4);

    // Vector table, one entry per clock edge, starting from reset state.
    do_reset();
    add(1, 14'h0015, 0, 14'h0, 0, 14'h0,    14'h0,    0);
    add(0, 14'h0,    0, 14'h0, 1, 14'h0015, 14'h0015, 0);
    idle(1, 14'h0015, 0);
    add(1, 14'h0015, 0, 14'h0, 0, 14'h0,    14'h0015, 0);
    idle(1, 14'h0015, 0);
    add(0, 14'h0, 1, 14'h3FFF, 0, 14'h0,    14'h0015, 1);
    add(0, 14'h0, 0, 14'h0,    1, 14'h3FFF, 14'h3FFF, 1);
    idle(3, 14'h3FFF, 1);
    add(0, 14'h0, 0, 14'h0,    1, 14'h0,    14'h0,    1);
    idle(3, 14'h0, 1);
    add(0, 14'h0, 0, 14'h0,    1, 14'h3FFF, 14'h3FFF, 1);
    idle(3, 14'h3FFF, 1);
    add(0, 14'h0, 0, 14'h0,    1, 14'h0,    14'h0,    1);
    idle(2, 14'h0, 1);
    idle(1, 14'h0, 0);
    add(0, 14'h0, 0, 14'h0,    1, 14'h0015, 14'h0015, 0);
    idle(1, 14'h0015, 0);
    add(0, 14'h0,    1, 14'h0AAA, 0, 14'h0,    14'h0015, 1);
    add(0, 14'h0,    0, 14'h0,    1, 14'h0AAA, 14'h0AAA, 1);
    add(1, 14'h0003, 1, 14'h1111, 0, 14'h0,    14'h0AAA, 1);
    idle(2, 14'h0AAA, 1);
    add(0, 14'h0,    0, 14'h0,    1, 14'h0,    14'h0,    1);
    idle(3, 14'h0, 1);
    add(0, 14'h0,    0, 14'h0,    1, 14'h0AAA, 14'h0AAA, 1);
    add(0, 14'h0,    1, 14'h2222, 0, 14'h0,    14'h0AAA, 1);
    idle(2, 14'h0AAA, 1);
    add(0, 14'h0,    0, 14'h0,    1, 14'h0,    14'h0,    1);
    idle(2, 14'h0, 1);
    idle(1, 14'h0, 0);
    add(0, 14'h0,    0, 14'h0,    1, 14'h0003, 14'h0003, 0);
    idle(2, 14'h0003, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      level_valid = vecs[i].lv;
      level_value = vecs[i].val;
      event_req = vecs[i].ev;
      event_pattern = vecs[i].pat;
      @(posedge clk);
      #1;
      $display("step %0d: lv=%0b val=0x%0h ev=%0b pat=0x%0h -> cs=%0b wd=0x%0h shown=0x%0h busy=%0b",
               i, vecs[i].lv, vecs[i].val, vecs[i].ev, vecs[i].pat,
               avm_chipselect, avm_writedata, shown_value, event_busy);
      check($sformatf("step%0d_cs", i), {31'b0, avm_chipselect}, {31'b0, vecs[i].cs});
      check($sformatf("step%0d_write_n", i), {31'b0, avm_write_n}, {31'b0, ~vecs[i].cs});
      if (vecs[i].cs) check($sformatf("step%0d_writedata", i), avm_writedata, {18'b0, vecs[i].wd});
      check($sformatf("step%0d_shown", i), {18'b0, shown_value}, {18'b0, vecs[i].shown});
      check($sformatf("step%0d_busy", i), {31'b0, event_busy}, {31'b0, vecs[i].busy});
      check($sformatf("step%0d_addr", i), {30'b0, avm_address}, 32'd0);
    end
    @(negedge clk);
    level_valid = 1'b0;
    event_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
